// File: rtl/lsu_pkg.sv
// Shared load/store encodings, controller state constants and request classification helpers.
package lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_SPLIT  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic logic is_illegal(input logic [2:0] t);
        return (t == 3'b011) || (t == 3'b110) || (t == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
        case (t)
            LS_H, LS_HU: return a[0];
            LS_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational sign/zero extension of assembled split-load data by access type.
// Zero latency; no flow control.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_type)
            LS_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
            LS_BU:   o_data = {24'd0, i_data[7:0]};
            LS_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
            LS_HU:   o_data = {16'd0, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, RAM access 1 cycle (N bytes when split), response pulse after.
// Accepts in IDLE and RESP; response has no backpressure. LSU_MISALIGN_SPLIT_EN builds the byte-split path.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_fault,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_rw_type,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic [1:0]       r_state;
    logic             r_we;
    logic             r_fault;
    logic [TAG_W-1:0] r_tag;

    logic w_hs;
    logic w_illegal;
    logic w_mis;
    logic w_fault;

    assign req_ready = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_hs      = req_valid && req_ready;
    assign w_illegal = is_illegal(req_type);
    assign w_mis     = is_misaligned(req_type, req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_cnt;
    logic [31:0]       r_asm;

    logic              w_split;
    logic [1:0]        w_cnt_nxt;
    logic [1:0]        w_last;
    logic [31:0]       w_asm_nxt;
    logic [31:0]       w_ext;

    assign w_split   = w_mis && !w_illegal;
    assign w_fault   = w_illegal;
    assign w_cnt_nxt = r_cnt + 2'd1;
    assign w_last    = (r_type == LS_W) ? 2'd3 : 2'd1;

    // Byte k of the RAM beat lands in assembly lane k; the last beat is folded in before extension.
    always_comb begin
        w_asm_nxt = r_asm;
        w_asm_nxt[{r_cnt, 3'b000} +: 8] = mem_rdata[7:0];
    end

    lsu_load_ext u_ext (
        .i_type (r_type),
        .i_data (w_asm_nxt),
        .o_data (w_ext)
    );
`else
    assign w_fault = w_illegal || w_mis;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_fault     <= 1'b0;
            r_tag       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_tag     <= '0;
            rsp_fault   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_rw_type <= 3'd0;
            mem_wdata   <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_type      <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_cnt       <= 2'd0;
            r_asm       <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    rsp_valid <= 1'b0;
                    if (w_hs) begin
                        r_we    <= req_we;
                        r_tag   <= req_tag;
                        r_fault <= w_fault;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_type  <= req_type;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 2'd0;
                        r_asm   <= 32'd0;
                        if (w_split) begin
                            r_state     <= ST_SPLIT;
                            mem_addr    <= req_addr;
                            mem_rw_type <= req_we ? LS_B : LS_BU;
                            mem_wdata   <= {24'd0, req_wdata[7:0]};
                            mem_wr_en   <= req_we;
                            mem_rd_en   <= !req_we;
                        end else
`endif
                        begin
                            r_state <= ST_ACCESS;
                            // Faulting requests leave the RAM lines untouched.
                            if (!w_fault) begin
                                mem_addr    <= req_addr;
                                mem_rw_type <= req_type;
                                mem_wdata   <= req_wdata;
                                mem_wr_en   <= req_we;
                                mem_rd_en   <= !req_we;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    mem_wr_en <= 1'b0;
                    mem_rd_en <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_tag   <= r_tag;
                    rsp_fault <= r_fault;
                    rsp_rdata <= (r_fault || r_we) ? 32'd0 : mem_rdata;
                    r_state   <= ST_RESP;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_SPLIT: begin
                    r_asm <= w_asm_nxt;
                    if (r_cnt == w_last) begin
                        mem_wr_en <= 1'b0;
                        mem_rd_en <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_tag   <= r_tag;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= r_we ? 32'd0 : w_ext;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                        mem_addr  <= r_addr + ADDR_W'(w_cnt_nxt);
                        mem_wdata <= {24'd0, r_wdata[{w_cnt_nxt, 3'b000} +: 8]};
                    end
                end
`endif
                default: begin
                    mem_wr_en <= 1'b0;
                    mem_rd_en <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-array RAM model; expectations follow the build's split option.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_tag;
    logic        rsp_fault;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [2:0]  mem_rw_type;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        ram_init;
    logic [7:0]  ram [0:255];
    logic [7:0]  ra;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .TAG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_type    (req_type),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_tag     (rsp_tag),
        .rsp_fault   (rsp_fault),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rw_type (mem_rw_type),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    assign ra = mem_addr[7:0];

    always_comb begin
        mem_rdata = 32'd0;
        case (mem_rw_type)
            3'b000: mem_rdata = {{24{ram[ra][7]}}, ram[ra]};
            3'b100: mem_rdata = {24'd0, ram[ra]};
            3'b001: mem_rdata = {{16{ram[ra+8'd1][7]}}, ram[ra+8'd1], ram[ra]};
            3'b101: mem_rdata = {16'd0, ram[ra+8'd1], ram[ra]};
            3'b010: mem_rdata = {ram[ra+8'd3], ram[ra+8'd2], ram[ra+8'd1], ram[ra]};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h00] <= 8'h0D; ram[8'h01] <= 8'hF0; ram[8'h02] <= 8'hFE; ram[8'h03] <= 8'hCA;
            ram[8'h04] <= 8'h78; ram[8'h05] <= 8'h56; ram[8'h06] <= 8'h34; ram[8'h07] <= 8'h12;
            ram[8'h10] <= 8'hEF; ram[8'h11] <= 8'hBE; ram[8'h12] <= 8'hAD; ram[8'h13] <= 8'hDE;
            ram[8'h21] <= 8'h80; ram[8'h22] <= 8'hFF;
            ram[8'h40] <= 8'h44; ram[8'h41] <= 8'h33; ram[8'h42] <= 8'h22; ram[8'h43] <= 8'h11;
        end else if (mem_wr_en) begin
            case (mem_rw_type)
                3'b000: ram[ra] <= mem_wdata[7:0];
                3'b001: begin
                    ram[ra]      <= mem_wdata[7:0];
                    ram[ra+8'd1] <= mem_wdata[15:8];
                end
                3'b010: begin
                    ram[ra]      <= mem_wdata[7:0];
                    ram[ra+8'd1] <= mem_wdata[15:8];
                    ram[ra+8'd2] <= mem_wdata[23:16];
                    ram[ra+8'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] tag);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = d;
        req_tag   = tag;
    endtask

    task automatic drop();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_tag = 5'd0;
        tick(); tick();
        rst = 1'b0; ram_init = 1'b0;

        chk("rst_ready",   32'(req_ready),   32'd1);
        chk("rst_rsp_vld", 32'(rsp_valid),   32'd0);
        chk("rst_rdata",   rsp_rdata,        32'd0);
        chk("rst_wr_en",   32'(mem_wr_en),   32'd0);
        chk("rst_rd_en",   32'(mem_rd_en),   32'd0);
        chk("rst_addr",    mem_addr,         32'd0);
        chk("rst_rwtype",  32'(mem_rw_type), 32'd0);

        // aligned lw 0x10
        issue(1'b0, 3'b010, 32'h10, 32'd0, 5'd7);
        chk("lw_ready_c0", 32'(req_ready), 32'd1);
        tick(); drop();
        chk("lw_rd_en_c1", 32'(mem_rd_en),   32'd1);
        chk("lw_wr_en_c1", 32'(mem_wr_en),   32'd0);
        chk("lw_addr_c1",  mem_addr,         32'h10);
        chk("lw_type_c1",  32'(mem_rw_type), 32'd2);
        chk("lw_rsp_c1",   32'(rsp_valid),   32'd0);
        tick();
        chk("lw_rsp_c2",   32'(rsp_valid), 32'd1);
        chk("lw_rdata",    rsp_rdata,      32'hDEADBEEF);
        chk("lw_tag",      32'(rsp_tag),   32'd7);
        chk("lw_fault",    32'(rsp_fault), 32'd0);
        chk("lw_rd_off",   32'(mem_rd_en), 32'd0);
        tick();
        chk("lw_rsp_c3",   32'(rsp_valid), 32'd0);

        // sb 0xA5 to 0x43 then lw 0x40 issued during RESP
        issue(1'b1, 3'b000, 32'h43, 32'h000000A5, 5'd1);
        tick(); drop();
        chk("sb_wr_en_c1", 32'(mem_wr_en),   32'd1);
        chk("sb_type_c1",  32'(mem_rw_type), 32'd0);
        chk("sb_wdata_c1", mem_wdata,        32'hA5);
        tick();
        chk("sb_wr_off_c2", 32'(mem_wr_en), 32'd0);
        chk("sb_rsp_c2",    32'(rsp_valid), 32'd1);
        chk("sb_rdata",     rsp_rdata,      32'd0);
        issue(1'b0, 3'b010, 32'h40, 32'd0, 5'd2);
        tick(); drop();
        tick();
        chk("sb_lw_rdata", rsp_rdata, 32'hA5223344);

        // lh at 0x21
        tick();
        issue(1'b0, 3'b001, 32'h21, 32'd0, 5'd3);
        tick(); drop();
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("lh_rd_en_c1", 32'(mem_rd_en),   32'd1);
        chk("lh_type_c1",  32'(mem_rw_type), 32'd4);
        chk("lh_addr_c1",  mem_addr,         32'h21);
        tick();
        chk("lh_rd_en_c2", 32'(mem_rd_en),   32'd1);
        chk("lh_addr_c2",  mem_addr,         32'h22);
        chk("lh_rsp_c2",   32'(rsp_valid),   32'd0);
        tick();
        chk("lh_rsp_c3",   32'(rsp_valid),   32'd1);
        chk("lh_rdata",    rsp_rdata,        32'hFFFFFF80);
        chk("lh_fault",    32'(rsp_fault),   32'd0);
        chk("lh_rd_off",   32'(mem_rd_en),   32'd0);
`else
        chk("lh_rd_en_c1", 32'(mem_rd_en),   32'd0);
        chk("lh_wr_en_c1", 32'(mem_wr_en),   32'd0);
        tick();
        chk("lh_rsp_c2",   32'(rsp_valid),   32'd1);
        chk("lh_fault",    32'(rsp_fault),   32'd1);
        chk("lh_rdata",    rsp_rdata,        32'd0);
        chk("lh_tag",      32'(rsp_tag),     32'd3);
`endif

        // sw 0x01020304 to 0x31
        tick();
        issue(1'b1, 3'b010, 32'h31, 32'h01020304, 5'd4);
        tick(); drop();
`ifdef LSU_MISALIGN_SPLIT_EN
        for (int k = 0; k < 4; k++) begin
            chk("sw_wr_en",  32'(mem_wr_en),   32'd1);
            chk("sw_type",   32'(mem_rw_type), 32'd0);
            chk("sw_addr",   mem_addr,         32'h31 + 32'(k));
            chk("sw_wdata",  mem_wdata,        32'(4 - k));
            tick();
        end
        chk("sw_rsp",   32'(rsp_valid), 32'd1);
        chk("sw_fault", 32'(rsp_fault), 32'd0);
        chk("sw_rdata", rsp_rdata,      32'd0);
        chk("sw_wr_off", 32'(mem_wr_en), 32'd0);
`else
        chk("sw_wr_en_c1", 32'(mem_wr_en), 32'd0);
        tick();
        chk("sw_fault", 32'(rsp_fault), 32'd1);
`endif
        tick();
        issue(1'b0, 3'b010, 32'h30, 32'd0, 5'd5);
        tick(); drop(); tick();
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("sw_chk30", rsp_rdata, 32'h02030400);
`else
        chk("sw_chk30", rsp_rdata, 32'h00000000);
`endif
        issue(1'b0, 3'b010, 32'h34, 32'd0, 5'd6);
        tick(); drop(); tick();
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("sw_chk34", rsp_rdata, 32'h00000001);
`else
        chk("sw_chk34", rsp_rdata, 32'h00000000);
`endif

        // illegal type 111 store
        tick();
        issue(1'b1, 3'b111, 32'h50, 32'hFFFFFFFF, 5'd9);
        tick(); drop();
        chk("ill_wr_en_c1", 32'(mem_wr_en), 32'd0);
        chk("ill_rd_en_c1", 32'(mem_rd_en), 32'd0);
        tick();
        chk("ill_rsp",   32'(rsp_valid), 32'd1);
        chk("ill_fault", 32'(rsp_fault), 32'd1);
        chk("ill_rdata", rsp_rdata,      32'd0);
        chk("ill_tag",   32'(rsp_tag),   32'd9);

        // back-to-back lw 0x0 / 0x4; second held during ACCESS
        tick();
        issue(1'b0, 3'b010, 32'h0, 32'd0, 5'd10);
        tick();
        issue(1'b0, 3'b010, 32'h4, 32'd0, 5'd11);
        chk("b2b_ready_c1", 32'(req_ready), 32'd0);
        chk("b2b_addr_c1",  mem_addr,       32'h0);
        tick();
        chk("b2b_rsp_c2",   32'(rsp_valid), 32'd1);
        chk("b2b_rdata0",   rsp_rdata,      32'hCAFEF00D);
        chk("b2b_tag0",     32'(rsp_tag),   32'd10);
        chk("b2b_ready_c2", 32'(req_ready), 32'd1);
        tick(); drop();
        chk("b2b_rsp_c3",   32'(rsp_valid), 32'd0);
        chk("b2b_addr_c3",  mem_addr,       32'h4);
        tick();
        chk("b2b_rsp_c4",   32'(rsp_valid), 32'd1);
        chk("b2b_rdata1",   rsp_rdata,      32'h12345678);
        chk("b2b_tag1",     32'(rsp_tag),   32'd11);

        // reset in the middle of a misaligned store
        tick();
        issue(1'b1, 3'b010, 32'h61, 32'hAABBCCDD, 5'd12);
        tick(); drop();
`ifdef LSU_MISALIGN_SPLIT_EN
        tick();
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mid_rsp",   32'(rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        tick();
        chk("rst_mid_rsp2",  32'(rsp_valid), 32'd0);
        chk("rst_mid_wr2",   32'(mem_wr_en), 32'd0);
        issue(1'b0, 3'b010, 32'h60, 32'd0, 5'd13);
        tick(); drop(); tick();
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("rst_mid_mem", rsp_rdata, 32'h00CCDD00);
`else
        chk("rst_mid_mem", rsp_rdata, 32'h00000000);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
